// File: rtl/weight_scratchpad_pp.sv
// Ping-pong weight scratchpad: one bank fills column-by-column while the other is replayed to the PE array.
// Optional lane parity storage/check is enabled by defining SCRATCHPAD_PARITY_EN.
module weight_scratchpad_pp #(
  parameter int unsigned WEIGHT_WIDTH = 5,
  parameter int unsigned WEIGHT_ROWS  = 6,
  parameter int unsigned WEIGHT_COLS  = 3,
  parameter int unsigned REUSE_W      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [WEIGHT_WIDTH-1:0]         wr_data [0:WEIGHT_ROWS-1],
  input  logic                            rd_req,
  output logic                            rd_avail,
  input  logic [REUSE_W-1:0]              reuse,
  output logic                            rd_valid,
  output logic [WEIGHT_WIDTH-1:0]         rd_data [0:WEIGHT_ROWS-1],
  output logic [$clog2(WEIGHT_COLS)-1:0]  rd_col,
  output logic                            rd_last,
`ifdef SCRATCHPAD_PARITY_EN
  output logic                            par_err,
`endif
  output logic [1:0]                      bank_full
);

  localparam int unsigned CW = $clog2(WEIGHT_COLS);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [WEIGHT_WIDTH-1:0] r_mem [2][WEIGHT_COLS][WEIGHT_ROWS];

  logic [0:0]          r_state,     w_state_n;
  logic                r_wr_bank,   w_wr_bank_n;
  logic                r_rd_bank,   w_rd_bank_n;
  logic [CW-1:0]       r_wr_col,    w_wr_col_n;
  logic [CW-1:0]       r_rd_ptr,    w_rd_ptr_n;
  logic [REUSE_W-1:0]  r_pass,      w_pass_n;
  logic [REUSE_W-1:0]  r_reuse_q,   w_reuse_q_n;
  logic [1:0]          r_full,      w_full_n;

  logic                    r_rd_valid;
  logic                    r_rd_last;
  logic [CW-1:0]           r_rd_col;
  logic [WEIGHT_WIDTH-1:0] r_rd_data [WEIGHT_ROWS];

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_wr_wrap;
  logic                w_rd_wrap;
  logic                w_pass_last;
  logic                w_rd_end;
  logic [REUSE_W-1:0]  w_reuse_eff;
  logic [REUSE_W-1:0]  w_cur_reuse;

  assign wr_ready  = !r_full[r_wr_bank];
  assign rd_avail  = r_full[r_rd_bank];
  assign bank_full = r_full;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_col    = r_rd_col;
  assign rd_data   = r_rd_data;

  // A read accepted during flush still delivers its beat; writes during flush are dropped.
  assign w_wr_acc    = wr_valid && wr_ready && !flush;
  assign w_rd_acc    = rd_req && rd_avail;
  assign w_wr_wrap   = (r_wr_col == CW'(WEIGHT_COLS - 1));
  assign w_rd_wrap   = (r_rd_ptr == CW'(WEIGHT_COLS - 1));
  assign w_reuse_eff = (reuse == '0) ? REUSE_W'(1) : reuse;
  assign w_cur_reuse = (r_state == IDLE) ? w_reuse_eff : r_reuse_q;
  assign w_pass_last = (r_pass == REUSE_W'(w_cur_reuse - REUSE_W'(1)));
  assign w_rd_end    = w_rd_acc && w_rd_wrap && w_pass_last;

  // Next-state logic for pointers, bank flags and the read FSM.
  always_comb begin
    w_state_n   = r_state;
    w_wr_bank_n = r_wr_bank;
    w_rd_bank_n = r_rd_bank;
    w_wr_col_n  = r_wr_col;
    w_rd_ptr_n  = r_rd_ptr;
    w_pass_n    = r_pass;
    w_reuse_q_n = r_reuse_q;
    w_full_n    = r_full;

    if (w_rd_acc) begin
      if (r_state == IDLE) begin
        w_reuse_q_n = w_reuse_eff;
        w_state_n   = STREAM;
      end
      if (w_rd_wrap) begin
        w_rd_ptr_n = '0;
        if (w_pass_last) begin
          w_pass_n              = '0;
          w_full_n[r_rd_bank]   = 1'b0;
          w_rd_bank_n           = !r_rd_bank;
          w_state_n             = IDLE;
        end else begin
          w_pass_n = r_pass + REUSE_W'(1);
        end
      end else begin
        w_rd_ptr_n = r_rd_ptr + CW'(1);
      end
    end

    // Releasing and completing banks always hit different banks, so both updates can apply.
    if (w_wr_acc) begin
      if (w_wr_wrap) begin
        w_wr_col_n          = '0;
        w_full_n[r_wr_bank] = 1'b1;
        w_wr_bank_n         = !r_wr_bank;
      end else begin
        w_wr_col_n = r_wr_col + CW'(1);
      end
    end

    if (flush) begin
      w_state_n   = IDLE;
      w_wr_bank_n = 1'b0;
      w_rd_bank_n = 1'b0;
      w_wr_col_n  = '0;
      w_rd_ptr_n  = '0;
      w_pass_n    = '0;
      w_reuse_q_n = '0;
      w_full_n    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_col  <= '0;
      r_rd_ptr  <= '0;
      r_pass    <= '0;
      r_reuse_q <= '0;
      r_full    <= 2'b00;
    end else begin
      r_state   <= w_state_n;
      r_wr_bank <= w_wr_bank_n;
      r_rd_bank <= w_rd_bank_n;
      r_wr_col  <= w_wr_col_n;
      r_rd_ptr  <= w_rd_ptr_n;
      r_pass    <= w_pass_n;
      r_reuse_q <= w_reuse_q_n;
      r_full    <= w_full_n;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_bank][r_wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_col   <= '0;
      for (int i = 0; i < WEIGHT_ROWS; i++) begin
        r_rd_data[i] <= '0;
      end
    end else begin
      r_rd_valid <= w_rd_acc;
      r_rd_last  <= w_rd_end;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_bank][r_rd_ptr];
        r_rd_col  <= r_rd_ptr;
      end
    end
  end

`ifdef SCRATCHPAD_PARITY_EN
  logic [WEIGHT_ROWS-1:0] r_par [2][WEIGHT_COLS];
  logic                   r_par_err;
  logic [WEIGHT_ROWS-1:0] w_par_wr;
  logic [WEIGHT_ROWS-1:0] w_par_chk;

  // Even parity per lane: stored bit makes the lane plus parity an even count of ones.
  always_comb begin
    w_par_wr  = '0;
    w_par_chk = '0;
    for (int i = 0; i < WEIGHT_ROWS; i++) begin
      w_par_wr[i]  = ^wr_data[i];
      w_par_chk[i] = (^r_mem[r_rd_bank][r_rd_ptr][i]) ^ r_par[r_rd_bank][r_rd_ptr][i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_par[r_wr_bank][r_wr_col] <= w_par_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (flush) begin
      r_par_err <= 1'b0;
    end else if (w_rd_acc && (|w_par_chk)) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_weight_scratchpad_pp.sv
// Bench for weight_scratchpad_pp: directed and random traffic checked against a bank/beat queue model.
// Define SCRATCHPAD_PARITY_EN to also exercise the parity path.
module tb_weight_scratchpad_pp;

  localparam int unsigned W    = 5;
  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 3;
  localparam int unsigned RW   = 4;
  localparam int unsigned DW   = W * ROWS;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    c;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data [0:ROWS-1];
  logic          rd_req;
  logic          rd_avail;
  logic [RW-1:0] reuse;
  logic          rd_valid;
  logic [W-1:0]  rd_data [0:ROWS-1];
  logic [1:0]    rd_col;
  logic          rd_last;
  logic [1:0]    bank_full;
`ifdef SCRATCHPAD_PARITY_EN
  logic          par_err;
`endif

  weight_scratchpad_pp #(
    .WEIGHT_WIDTH(W), .WEIGHT_ROWS(ROWS), .WEIGHT_COLS(COLS), .REUSE_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_req(rd_req), .rd_avail(rd_avail), .reuse(reuse),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_col(rd_col), .rd_last(rd_last),
`ifdef SCRATCHPAD_PARITY_EN
    .par_err(par_err),
`endif
    .bank_full(bank_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: filled banks as a column FIFO, the writer's partial bank, and the pending beats of the bank being replayed.
  int            nbanks = 0;
  logic [DW-1:0] part_q [$];
  logic [DW-1:0] fifo_q [$];
  beat_t         beat_q [$];
  logic [DW-1:0] exp_data = '0;
  logic          exp_valid = 1'b0;
  logic          exp_last = 1'b0;
  logic [1:0]    exp_col = '0;
  logic          exp_par = 1'b0;
  int            bad_col = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] mkcol(input int base);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < ROWS; i++) r[i*W +: W] = W'(base + i);
    return r;
  endfunction

  function automatic logic [DW-1:0] rd_packed();
    logic [DW-1:0] r;
    for (int i = 0; i < ROWS; i++) r[i*W +: W] = rd_data[i];
    return r;
  endfunction

  task automatic model_clear();
    nbanks = 0;
    part_q.delete();
    fifo_q.delete();
    beat_q.delete();
    exp_par = 1'b0;
  endtask

  // One clock: drive inputs, check ready/avail before the edge, advance the model, check registered outputs after.
  task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rq,
                     input logic [RW-1:0] ru, input logic fl);
    logic  wf, rf;
    beat_t b;
    int    reff;
    wr_valid = wv; rd_req = rq; reuse = ru; flush = fl;
    for (int i = 0; i < ROWS; i++) wr_data[i] = wd[i*W +: W];
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(nbanks < 2));
    chk("rd_avail", 32'(rd_avail), 32'(nbanks > 0));
    wf = wv && (nbanks < 2) && !fl;
    rf = rq && (nbanks > 0) && !fl;
    @(posedge clk); #1;
    exp_valid = rf;
    exp_last  = 1'b0;
    if (rf) begin
      if (beat_q.size() == 0) begin
        reff = (ru == 0) ? 1 : int'(ru);
        for (int p = 0; p < reff; p++)
          for (int c = 0; c < COLS; c++) begin
            b.d = fifo_q[c];
            b.c = 2'(c);
            b.l = (p == reff - 1) && (c == COLS - 1);
            beat_q.push_back(b);
          end
      end
      b = beat_q.pop_front();
      exp_data = b.d;
      exp_col  = b.c;
      exp_last = b.l;
      if (bad_col == int'(b.c)) exp_par = 1'b1;
      if (b.l) begin
        for (int c = 0; c < COLS; c++) void'(fifo_q.pop_front());
        nbanks--;
      end
    end
    if (wf) begin
      part_q.push_back(wd);
      if (part_q.size() == COLS) begin
        foreach (part_q[k]) fifo_q.push_back(part_q[k]);
        part_q.delete();
        nbanks++;
      end
    end
    if (fl) model_clear();
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("rd_data", 32'(rd_packed()), 32'(exp_data));
    chk("rd_last", 32'(rd_last), 32'(exp_last));
    chk("bank_cnt", 32'($countones(bank_full)), 32'(nbanks));
    if (exp_valid) chk("rd_col", 32'(rd_col), 32'(exp_col));
`ifdef SCRATCHPAD_PARITY_EN
    chk("par_err", 32'(par_err), 32'(exp_par));
`endif
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0; reuse = '0;
    for (int i = 0; i < ROWS; i++) wr_data[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_packed()), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_rd_avail"}, 32'(rd_avail), 32'd0);
    chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({tag, "_bank_full"}, 32'(bank_full), 32'd0);
  endtask

  initial begin
    int base;
    logic wv, rq, fl;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Fill/drain with reuse=1.
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(6 * c), 1'b0, 4'd1, 1'b0);
    chk("t2_full01", 32'(bank_full), 32'b01);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 4'd1, 1'b0);
    chk("t2_lane0_last", 32'(rd_data[0]), 32'd12);
    chk("t2_last", 32'(rd_last), 32'd1);
    chk("t2_full00", 32'(bank_full), 32'b00);
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b0);
    chk("t2_hold", 32'(rd_data[0]), 32'd12);

    // Replay: reuse=3 gives 9 beats, reuse=0 gives 3.
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(20 + c), 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, '0, 1'b1, 4'd3, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(3 + c), 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, 4'd0, 1'b0);

    // Ping-pong overlap: stream B0 twice while B1 fills, then a stalled write waits for the release.
    base = 1;
    for (int c = 0; c < 3; c++) begin cyc(1'b1, mkcol(base), 1'b0, 4'd2, 1'b0); base++; end
    for (int k = 0; k < 14; k++) begin
      wv = (k < 7);
      cyc(wv, mkcol(base), 1'b1, 4'd2, 1'b0);
      if (wv && wr_ready) base++;
    end

    // Flush mid-fill, then refill from col0.
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b1);
    for (int c = 0; c < 2; c++) cyc(1'b1, mkcol(9 + c), 1'b0, 4'd1, 1'b0);
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b1);
    chk("t5_full", 32'(bank_full), 32'b00);
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(14 + c), 1'b0, 4'd1, 1'b0);
    chk("t5_full01", 32'(bank_full), 32'b01);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 4'd1, 1'b0);

`ifdef SCRATCHPAD_PARITY_EN
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b1);
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(7 * c), 1'b0, 4'd1, 1'b0);
    dut.r_par[0][1][0] = ~dut.r_par[0][1][0];
    bad_col = 1;
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 4'd1, 1'b0);
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b0);
    bad_col = -1;
    cyc(1'b0, '0, 1'b0, 4'd1, 1'b1);
`endif

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      fl = ($urandom_range(0, 63) == 0);
      wv = !fl && ($urandom_range(0, 2) != 0);
      rq = !fl && ($urandom_range(0, 2) != 0);
      cyc(wv, DW'($urandom), rq, RW'($urandom_range(0, 3)), fl);
    end

    // Asynchronous reset in the middle of a stream.
    cyc(1'b0, '0, 1'b0, 4'd2, 1'b1);
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(2 + c), 1'b0, 4'd2, 1'b0);
    for (int k = 0; k < 2; k++) cyc(1'b0, '0, 1'b1, 4'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t1");
    model_clear();
    exp_data = '0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) cyc(1'b1, mkcol(11 + c), 1'b0, 4'd1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 4'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
